// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the Game Boy CPU front end.
// The fetch unit and the T-cycle counter both import this package.
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    FETCH,
    PREFIX,
    EXEC
  } fetch_state_t;

  localparam logic [7:0] CB_PREFIX = 8'hCB;
  localparam logic [1:0] T_LAST    = 2'd3;

endpackage

// File: rtl/gb_cpu_tcycle_counter.sv
// T-cycle timebase: a 2-bit counter that wraps every M-cycle and freezes while held.
// mcycle_end marks the final T-cycle of an M-cycle that is actually advancing.
module gb_cpu_tcycle_counter
  import gb_cpu_common_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  output logic [1:0] tcycle,
  output logic       mcycle_end
);

  always_ff @(posedge clk) begin
    if (reset) begin
      tcycle <= 2'd0;
    end else if (!hold) begin
      tcycle <= tcycle + 2'd1;
    end
  end

  assign mcycle_end = (tcycle == T_LAST) && !hold;

endmodule

// File: rtl/gb_cpu_fetch_unit.sv
// Instruction fetch / IR stage: latches opcode bytes at T3, tracks the 0xCB prefix,
// overlaps the next fetch with the last M-cycle, and injects interrupt dispatch.
module gb_cpu_fetch_unit
  import gb_cpu_common_pkg::*;
#(
  parameter logic [7:0] RESET_OPCODE   = 8'h00,
  parameter logic [7:0] CB_PREFIX_BYTE = CB_PREFIX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] mem_rdata,
  input  logic       last_mcycle,
  input  logic       hold,
  input  logic       irq_pending,
  output logic [1:0] tcycle,
  output logic       mcycle_end,
  output logic       fetch_active,
  output logic [7:0] opcode,
  output logic       cb_prefix,
  output logic       ir_valid,
  output logic       pc_inc,
  output logic       int_dispatch
);

  fetch_state_t state, state_next;
  logic [7:0]   opcode_next;
  logic         cb_prefix_next;
  logic         int_dispatch_next;
  logic         ir_valid_next;
  logic         pc_inc_next;
  logic         latch;

  gb_cpu_tcycle_counter u_tcycle (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .tcycle     (tcycle),
    .mcycle_end (mcycle_end)
  );

  assign fetch_active = (state == FETCH) || (state == PREFIX) ||
                        ((state == EXEC) && last_mcycle);

  // mcycle_end already excludes hold, so a held T3 never latches.
  assign latch = mcycle_end && fetch_active;

  always_comb begin
    state_next        = state;
    opcode_next       = opcode;
    cb_prefix_next    = cb_prefix;
    int_dispatch_next = int_dispatch;
    ir_valid_next     = 1'b0;
    pc_inc_next       = 1'b0;

    if (latch) begin
      if (irq_pending && (state != PREFIX)) begin
        // Dispatch replaces the fetched byte; PC must not advance past it.
        state_next        = EXEC;
        opcode_next       = 8'h00;
        cb_prefix_next    = 1'b0;
        int_dispatch_next = 1'b1;
        ir_valid_next     = 1'b1;
      end else if ((mem_rdata == CB_PREFIX_BYTE) && (state != PREFIX)) begin
        state_next  = PREFIX;
        pc_inc_next = 1'b1;
      end else begin
        state_next        = EXEC;
        opcode_next       = mem_rdata;
        cb_prefix_next    = (state == PREFIX);
        int_dispatch_next = 1'b0;
        ir_valid_next     = 1'b1;
        pc_inc_next       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      opcode       <= RESET_OPCODE;
      cb_prefix    <= 1'b0;
      int_dispatch <= 1'b0;
      ir_valid     <= 1'b0;
      pc_inc       <= 1'b0;
    end else begin
      state        <= state_next;
      opcode       <= opcode_next;
      cb_prefix    <= cb_prefix_next;
      int_dispatch <= int_dispatch_next;
      ir_valid     <= ir_valid_next;
      pc_inc       <= pc_inc_next;
    end
  end

endmodule
